// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects and size-extends the MEM/WB result, drives the
// register-file write port, and keeps per-register pending-write counters for ID.
module wb_commit_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mw_valid,
    input  logic        mw_reg_write,
    input  logic        mw_mem_to_reg,
    input  logic [4:0]  mw_rd,
    input  logic [2:0]  mw_funct3,
    input  logic [2:0]  mw_addr_lo,
    input  logic [63:0] mw_alu_result,
    input  logic [63:0] mw_mem_rdata,
    input  logic        stall,
    input  logic        issue_valid,
    input  logic        issue_reg_write,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_write_data,
    output logic        rf_reg_write,
    output logic        bypass1_hit,
    output logic        bypass2_hit,
    output logic [63:0] bypass_data,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        sb_overflow
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned CNTW = 2;

    logic [XLEN-1:0] w_lane_b;
    logic [XLEN-1:0] w_lane_h;
    logic [XLEN-1:0] w_lane_w;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_result;
    logic            w_accept;

    logic [RIDX-1:0] r_rf_rd;
    logic [XLEN-1:0] r_rf_write_data;
    logic            r_rf_reg_write;
    logic            r_sb_overflow;
    logic [CNTW-1:0] r_cnt [NREG];

    logic [NREG-1:0] w_inc;
    logic [NREG-1:0] w_dec;
    logic            w_ovf;

    // Lane alignment: the low address bits below the access size are ignored.
    assign w_lane_b = mw_mem_rdata >> {mw_addr_lo, 3'b000};
    assign w_lane_h = mw_mem_rdata >> {mw_addr_lo[2:1], 4'b0000};
    assign w_lane_w = mw_mem_rdata >> {mw_addr_lo[2], 5'b00000};

    always_comb begin
        w_load = mw_mem_rdata;
        case (mw_funct3)
            3'b000:  w_load = {{(XLEN-8){w_lane_b[7]}},   w_lane_b[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_lane_h[15]}}, w_lane_h[15:0]};
            3'b010:  w_load = {{(XLEN-32){w_lane_w[31]}}, w_lane_w[31:0]};
            3'b100:  w_load = {{(XLEN-8){1'b0}},  w_lane_b[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_lane_h[15:0]};
            3'b110:  w_load = {{(XLEN-32){1'b0}}, w_lane_w[31:0]};
            default: w_load = mw_mem_rdata;
        endcase
    end

    assign w_result = mw_mem_to_reg ? w_load : mw_alu_result;
    assign w_accept = mw_valid && !stall;

    // Commit register: one strobe per consumed entry, data held otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rf_rd         <= '0;
            r_rf_write_data <= '0;
            r_rf_reg_write  <= 1'b0;
        end else if (w_accept) begin
            r_rf_rd         <= mw_rd;
            r_rf_write_data <= w_result;
            r_rf_reg_write  <= mw_reg_write && (mw_rd != '0);
        end else begin
            r_rf_reg_write  <= 1'b0;
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_ovf = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_inc[i] = issue_valid && issue_reg_write && !stall && (issue_rd == RIDX'(i));
            w_dec[i] = r_rf_reg_write && (r_rf_rd == RIDX'(i));
            if (w_inc[i] && !w_dec[i] && (r_cnt[i] == CNTW'(3)))
                w_ovf = 1'b1;
        end
    end

    // Pending-write counters saturate at both ends; simultaneous inc/dec cancel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_cnt[i] <= '0;
            r_sb_overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_cnt[i] != CNTW'(3)))
                    r_cnt[i] <= r_cnt[i] + CNTW'(1);
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != CNTW'(0)))
                    r_cnt[i] <= r_cnt[i] - CNTW'(1);
            end
            if (w_ovf)
                r_sb_overflow <= 1'b1;
        end
    end

    assign rf_rd         = r_rf_rd;
    assign rf_write_data = r_rf_write_data;
    assign rf_reg_write  = r_rf_reg_write;
    assign sb_overflow   = r_sb_overflow;
    assign bypass_data   = r_rf_write_data;
    assign bypass1_hit   = r_rf_reg_write && (r_rf_rd == rs1) && (rs1 != '0);
    assign bypass2_hit   = r_rf_reg_write && (r_rf_rd == rs2) && (rs2 != '0);
    assign busy_rs1      = (r_cnt[rs1] != CNTW'(0));
    assign busy_rs2      = (r_cnt[rs2] != CNTW'(0));

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: a reference model predicts commits into a queue that a
// negedge monitor drains whenever the DUT strobes; counters are modelled per register.
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mw_valid, mw_reg_write, mw_mem_to_reg;
    logic [4:0]  mw_rd;
    logic [2:0]  mw_funct3, mw_addr_lo;
    logic [63:0] mw_alu_result, mw_mem_rdata;
    logic        stall, issue_valid, issue_reg_write;
    logic [4:0]  issue_rd, rs1, rs2;
    logic [4:0]  rf_rd;
    logic [63:0] rf_write_data, bypass_data;
    logic        rf_reg_write, bypass1_hit, bypass2_hit, busy_rs1, busy_rs2, sb_overflow;

    wb_commit_unit dut (
        .clk(clk), .reset(reset),
        .mw_valid(mw_valid), .mw_reg_write(mw_reg_write), .mw_mem_to_reg(mw_mem_to_reg),
        .mw_rd(mw_rd), .mw_funct3(mw_funct3), .mw_addr_lo(mw_addr_lo),
        .mw_alu_result(mw_alu_result), .mw_mem_rdata(mw_mem_rdata),
        .stall(stall), .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
        .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write),
        .bypass1_hit(bypass1_hit), .bypass2_hit(bypass2_hit), .bypass_data(bypass_data),
        .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          m_cnt[32];
    bit          m_ovf = 1'b0;
    bit          m_stb = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_data = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load extraction from access size and signedness with plain arithmetic.
    function automatic logic [63:0] ref_result(input logic m2r, input logic [2:0] f3,
                                               input logic [2:0] addr,
                                               input logic [63:0] alu, input logic [63:0] rdata);
        int          sz;
        int          off;
        logic [63:0] v;
        logic [63:0] mask;
        if (!m2r) return alu;
        sz = (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
        if (sz == 8) return rdata;
        off  = (int'(addr) / sz) * sz;
        mask = (64'd1 << (sz * 8)) - 64'd1;
        v    = (rdata >> (off * 8)) & mask;
        if (!f3[2] && v[sz*8-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model of one clock edge, evaluated on the inputs sampled at that edge.
    task automatic model_edge();
        int inc_i;
        int dec_i;
        if (!reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = 0; m_stb = 0; m_rd = '0; m_data = '0;
            exp_q.delete();
            return;
        end
        dec_i = m_stb ? int'(m_rd) : -1;
        inc_i = (issue_valid && issue_reg_write && issue_rd != 0 && !stall) ? int'(issue_rd) : -1;
        if (!(inc_i >= 0 && inc_i == dec_i)) begin
            if (inc_i >= 0) begin
                if (m_cnt[inc_i] == 3) m_ovf = 1;
                else m_cnt[inc_i]++;
            end
            if (dec_i >= 0 && m_cnt[dec_i] > 0) m_cnt[dec_i]--;
        end
        if (mw_valid && !stall) begin
            m_rd   = mw_rd;
            m_data = ref_result(mw_mem_to_reg, mw_funct3, mw_addr_lo, mw_alu_result, mw_mem_rdata);
            m_stb  = mw_reg_write && (mw_rd != 0);
            if (m_stb) exp_q.push_back('{rd: m_rd, data: m_data});
        end else begin
            m_stb = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 1; mw_valid = 0; mw_reg_write = 0; mw_mem_to_reg = 0; mw_rd = 0;
        mw_funct3 = 0; mw_addr_lo = 0; mw_alu_result = 0; mw_mem_rdata = 0; stall = 0;
        issue_valid = 0; issue_reg_write = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic rand_inputs();
        mw_valid = 1'($urandom); mw_reg_write = 1'($urandom); mw_mem_to_reg = 1'($urandom);
        mw_rd = 5'($urandom_range(0, 7)); mw_funct3 = 3'($urandom); mw_addr_lo = 3'($urandom);
        mw_alu_result = {32'($urandom), 32'($urandom)};
        mw_mem_rdata  = {32'($urandom), 32'($urandom)};
        stall = ($urandom_range(0, 3) == 0);
        issue_valid = 1'($urandom); issue_reg_write = 1'($urandom);
        issue_rd = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    endtask

    // Monitor: every strobe must match the oldest predicted commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("strobe", 64'(rf_reg_write), 64'(m_stb));
            chk("rf_rd_hold", 64'(rf_rd), 64'(m_rd));
            chk("rf_data_hold", rf_write_data, m_data);
            if (rf_reg_write) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_strobe: got rd %0d expected no strobe at %0t", rf_rd, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_rd", 64'(rf_rd), 64'(e.rd));
                    chk("commit_data", rf_write_data, e.data);
                    chk("bypass_data", bypass_data, e.data);
                    chk("bypass1", 64'(bypass1_hit), 64'(rs1 == e.rd && rs1 != 0));
                    chk("bypass2", 64'(bypass2_hit), 64'(rs2 == e.rd && rs2 != 0));
                end
            end else begin
                chk("bypass1_idle", 64'(bypass1_hit), 64'd0);
                chk("bypass2_idle", 64'(bypass2_hit), 64'd0);
            end
            chk("busy_rs1", 64'(busy_rs1), 64'(m_cnt[rs1] != 0));
            chk("busy_rs2", 64'(busy_rs2), 64'(m_cnt[rs2] != 0));
            chk("sb_overflow", 64'(sb_overflow), 64'(m_ovf));
        end
    end

    localparam logic [63:0] LD_DATA = 64'h80FF_7F01_8000_00F0;
    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b011};
    logic [2:0]  ld_adr [5] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd0};
    logic [63:0] ld_exp [5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_00F0,
                                64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_80FF_7F01, LD_DATA};

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        idle();
        // Reset with random inputs for two edges.
        rand_inputs(); reset = 0; step();
        rand_inputs(); reset = 0; step();
        chk("rst_rf_rd", 64'(rf_rd), 64'd0);
        chk("rst_rf_data", rf_write_data, 64'd0);
        chk("rst_strobe", 64'(rf_reg_write), 64'd0);
        chk("rst_ovf", 64'(sb_overflow), 64'd0);
        idle(); step(); step();
        chk("idle_strobe", 64'(rf_reg_write), 64'd0);

        // ALU commit with bypass.
        mw_valid = 1; mw_reg_write = 1; mw_rd = 5; mw_alu_result = 64'h1234; rs1 = 5;
        step();
        chk("alu_strobe", 64'(rf_reg_write), 64'd1);
        chk("alu_data", rf_write_data, 64'h1234);
        chk("alu_byp1", 64'(bypass1_hit), 64'd1);
        mw_valid = 0; step();
        chk("alu_drop", 64'(rf_reg_write), 64'd0);

        // Load extension table.
        for (int k = 0; k < 5; k++) begin
            idle();
            mw_valid = 1; mw_reg_write = 1; mw_mem_to_reg = 1; mw_rd = 3;
            mw_mem_rdata = LD_DATA; mw_funct3 = ld_f3[k]; mw_addr_lo = ld_adr[k];
            step();
            chk("load_ext", rf_write_data, ld_exp[k]);
        end

        // x0 suppression.
        idle();
        mw_valid = 1; mw_reg_write = 1; mw_rd = 0;
        issue_valid = 1; issue_reg_write = 1; issue_rd = 0;
        step();
        chk("x0_strobe", 64'(rf_reg_write), 64'd0);
        chk("x0_busy", 64'(busy_rs1), 64'd0);

        // Scoreboard saturation, cancel, and drain.
        idle(); rs1 = 7; issue_valid = 1; issue_reg_write = 1; issue_rd = 7;
        step(); step(); step();
        chk("sb_busy3", 64'(busy_rs1), 64'd1);
        chk("sb_no_ovf", 64'(sb_overflow), 64'd0);
        step();
        chk("sb_ovf", 64'(sb_overflow), 64'd1);
        issue_valid = 0; mw_valid = 1; mw_reg_write = 1; mw_rd = 7; mw_alu_result = 64'h77;
        step();
        mw_valid = 0; issue_valid = 1;
        step();
        issue_valid = 0; mw_valid = 1;
        step(); step(); step();
        chk("sb_busy_last", 64'(busy_rs1), 64'd1);
        mw_valid = 0; step();
        chk("sb_drained", 64'(busy_rs1), 64'd0);

        // Stall holds the entry, then exactly one strobe.
        idle();
        mw_valid = 1; mw_reg_write = 1; mw_rd = 9; mw_alu_result = 64'hABCD; stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_no_strobe", 64'(rf_reg_write), 64'd0);
        end
        stall = 0; step();
        chk("stall_release", rf_write_data, 64'hABCD);
        chk("stall_strobe", 64'(rf_reg_write), 64'd1);
        mw_valid = 0; step();
        chk("stall_single", 64'(rf_reg_write), 64'd0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            reset = ($urandom_range(0, 59) != 0);
            step();
        end
        idle(); step(); step(); step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
